// File: rtl/kernel_pkg.sv
// Shared constants and FSM state encoding for the kernel feeder and its word generator.
package kernel_pkg;

    localparam int DATA_W    = 16;
    localparam int FRAME_LEN = 1026;
    localparam int CNT_W     = 11;
    localparam int TIMEOUT   = 64;
    localparam int GAP_LEN   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } feed_state_t;

endpackage

// File: rtl/kernel_stim_gen.sv
// Loadable incrementing word generator: word shows seed the cycle after load, then +1 per step.
// One cycle load/step latency; no backpressure (the kernel input port is valid-only).
module kernel_stim_gen #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] seed,
    input  logic              step,
    output logic [DATA_W-1:0] word
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
        end else if (load) begin
            word <= seed;
        end else if (step) begin
            // Natural wrap at 2**DATA_W is intended.
            word <= word + DATA_W'(1);
        end
    end

endmodule

// File: rtl/kernel_feeder.sv
// Drives one unbroken valid-only frame into the kernel, then captures/checks its result or times out.
// First word one cycle after start; no backpressure, valid held through WAIT so the kernel count never restarts.
module kernel_feeder #(
    parameter int DATA_W    = kernel_pkg::DATA_W,
    parameter int FRAME_LEN = kernel_pkg::FRAME_LEN,
    parameter int CNT_W     = kernel_pkg::CNT_W,
    parameter int TIMEOUT   = kernel_pkg::TIMEOUT,
    parameter int GAP_LEN   = kernel_pkg::GAP_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] k_in_data,
    output logic              k_in_valid,
    input  logic [DATA_W-1:0] k_out_data,
    input  logic              k_out_valid,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              match,
    output logic              timeout
);

    import kernel_pkg::*;

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W  = $clog2(GAP_LEN + 1);

    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(FRAME_LEN - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  LAST_GAP  = GAP_W'(GAP_LEN - 1);

    feed_state_t       state, state_nxt;
    logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
    logic [DATA_W-1:0] seed_q;
    logic              gen_load;
    logic              gen_step;
    logic              capture;
    logic              expire;

    kernel_stim_gen #(
        .DATA_W(DATA_W)
    ) u_stim_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .load (gen_load),
        .seed (seed),
        .step (gen_step),
        .word (k_in_data)
    );

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        wait_cnt_nxt = wait_cnt;
        gap_cnt_nxt  = gap_cnt;
        gen_load     = 1'b0;
        gen_step     = 1'b0;
        capture      = 1'b0;
        expire       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    gen_load     = 1'b1;
                    beat_cnt_nxt = '0;
                    wait_cnt_nxt = '0;
                    gap_cnt_nxt  = '0;
                    state_nxt    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (k_out_valid) begin
                    capture   = 1'b1;
                    state_nxt = ST_GAP;
                end else if (beat_cnt == LAST_BEAT) begin
                    // Last word stays on the bus through WAIT.
                    state_nxt = ST_WAIT;
                end else begin
                    gen_step     = 1'b1;
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                // A result arriving on the final wait cycle beats the timeout.
                if (k_out_valid) begin
                    capture   = 1'b1;
                    state_nxt = ST_GAP;
                end else if (wait_cnt == LAST_WAIT) begin
                    expire    = 1'b1;
                    state_nxt = ST_GAP;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt == LAST_GAP) begin
                    state_nxt = ST_IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            wait_cnt   <= '0;
            gap_cnt    <= '0;
            seed_q     <= '0;
            k_in_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            match      <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nxt;
            beat_cnt   <= beat_cnt_nxt;
            wait_cnt   <= wait_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            k_in_valid <= (state_nxt == ST_SEND) || (state_nxt == ST_WAIT);
            busy       <= (state_nxt != ST_IDLE);
            done       <= capture || expire;
            if (gen_load) begin
                seed_q  <= seed;
                result  <= '0;
                match   <= 1'b0;
                timeout <= 1'b0;
            end
            if (capture) begin
                result <= k_out_data;
                match  <= (k_out_data == seed_q);
            end
            if (expire) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_kernel_feeder.sv
// Scoreboard bench: stimulus queues per-frame expectations, a negedge monitor checks the word stream and results.
module tb_kernel_feeder;

    localparam int FL = 1026;
    localparam int GL = 2;

    typedef struct {
        logic [15:0] seed;
        logic [15:0] result;
        logic        match;
        logic        timeout;
        int          beats;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] seed = 16'h0;
    logic [15:0] k_in_data;
    logic        k_in_valid;
    logic [15:0] k_out_data;
    logic        k_out_valid;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        match;
    logic        timeout;

    int   checks = 0;
    int   errors = 0;
    int   kmode  = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    kernel_feeder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .seed       (seed),
        .k_in_data  (k_in_data),
        .k_in_valid (k_in_valid),
        .k_out_data (k_out_data),
        .k_out_valid(k_out_valid),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .match      (match),
        .timeout    (timeout)
    );

    // Behavioural kernel: after FL consecutive valid beats, returns the first word for one cycle.
    int          k_cnt;
    logic [15:0] k_first;
    logic [15:0] m_data;
    logic        m_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_cnt   <= 0;
            k_first <= 16'h0;
            m_data  <= 16'h0;
            m_valid <= 1'b0;
        end else if (!k_in_valid) begin
            k_cnt   <= 0;
            m_valid <= 1'b0;
        end else begin
            if (k_cnt == 0) k_first <= k_in_data;
            m_valid <= (k_cnt == FL - 1);
            m_data  <= (k_cnt == 0) ? k_in_data : k_first;
            k_cnt   <= k_cnt + 1;
        end
    end

    // kmode 0: model, 1: stub that never answers, 2: stub answering 0xBEEF.
    assign k_out_valid = (kmode == 1) ? 1'b0 : m_valid;
    assign k_out_data  = (kmode == 2) ? 16'hBEEF : m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    bit          in_frame = 0;
    bit          in_gap   = 0;
    int          beats;
    int          gaps;
    int          bad;
    exp_t        cur;
    logic [15:0] ew;

    always @(negedge clk) begin
        if (!rst_n) begin
            if (in_frame && exp_q.size() > 0) cur = exp_q.pop_front();
            in_frame = 0;
            in_gap   = 0;
        end else begin
            if (done && !in_frame) chk("spurious_done", 1, 0);
            if (k_in_valid && !in_frame) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    cur      = exp_q[0];
                    in_frame = 1;
                    beats    = 0;
                    bad      = 0;
                end
            end
            if (in_frame) begin
                if (k_in_valid) begin
                    ew = (beats < FL) ? cur.seed + 16'(beats) : cur.seed + 16'(FL - 1);
                    if (k_in_data !== ew || busy !== 1'b1) begin
                        if (bad == 0)
                            $display("first bad beat %0d: data 0x%0h want 0x%0h busy %0b",
                                     beats, k_in_data, ew, busy);
                        bad++;
                    end
                    beats++;
                end else begin
                    chk("done_at_valid_fall", done, 1);
                    cur      = exp_q.pop_front();
                    in_frame = 0;
                    chk("frame_data_errors", bad, 0);
                    chk("valid_beats", beats, cur.beats);
                    chk("result", result, cur.result);
                    chk("match", match, cur.match);
                    chk("timeout", timeout, cur.timeout);
                    in_gap = 1;
                    gaps   = 0;
                end
            end
            if (in_gap) begin
                if (busy && !k_in_valid) begin
                    gaps++;
                end else begin
                    chk("gap_len", gaps, GL);
                    in_gap = 0;
                end
            end
        end
    end

    task automatic run_frame(input logic [15:0] s, input logic [15:0] r,
                             input logic m, input logic t, input int b);
        exp_t e;
        e.seed = s; e.result = r; e.match = m; e.timeout = t; e.beats = b;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        seed  = s;
        @(negedge clk);
        start = 1'b0;
        chk("start_clears_status", {14'h0, result, match, timeout}, 0);
        chk("first_word", {15'h0, k_in_valid, k_in_data}, {15'h0, 1'b1, s});
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", busy, 0);
        @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid_busy_done", {k_in_valid, busy, done}, 0);
        chk("reset_data_result", {k_in_data, result}, 0);
        chk("reset_match_timeout", {match, timeout}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        kmode = 0;
        run_frame(16'h1234, 16'h1234, 1'b1, 1'b0, FL + 1);
        wait_idle();
        run_frame(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, FL + 1);
        wait_idle();

        kmode = 1;
        run_frame(16'h3333, 16'h0000, 1'b0, 1'b1, FL + 64);
        wait_idle();

        kmode = 2;
        run_frame(16'h0042, 16'hBEEF, 1'b0, 1'b0, FL + 1);
        wait_idle();
        kmode = 0;

        // Starts during SEND and GAP must be ignored; seed input changes must not leak in.
        run_frame(16'h0100, 16'h0100, 1'b1, 1'b0, FL + 1);
        repeat (10) @(negedge clk);
        start = 1'b1;
        seed  = 16'h5555;
        @(negedge clk);
        start = 1'b0;
        chk("busy_during_send", {15'h0, busy, k_in_data}, {15'h0, 1'b1, 16'h010B});
        begin
            int n = 0;
            while (!done && n < 3000) begin
                @(negedge clk);
                n++;
            end
        end
        chk("done_seen", done, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_during_gap", {busy, k_in_valid}, 2'b10);
        wait_idle();
        repeat (10) @(negedge clk);
        chk("no_extra_frame", {busy, k_in_valid}, 0);

        // Reset mid-frame at beat 500.
        run_frame(16'h0777, 16'h0777, 1'b1, 1'b0, FL + 1);
        repeat (500) @(negedge clk);
        chk("beat500_word", k_in_data, 16'h0777 + 16'd500);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_mid_valid", k_in_valid, 0);
        chk("reset_mid_outputs", {k_in_data, busy, done, result, match, timeout}, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(16'h00AA, 16'h00AA, 1'b1, 1'b0, FL + 1);
        wait_idle();
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
